dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arb_pkg.sv | 21 ++
 rtl/dm_arbiter_if.sv | 34 +++
 rtl/dm_lane.sv | 60 ++++++
 rtl/dm_arbiter.sv | 142 ++++++++++++++
 tb/tb_dm_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and encodings for the two-port data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ACC  = 2'b01,
        S_RESP = 2'b10
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester handshake and data-memory bus bundle for dm_arbiter.
interface dm_arbiter_if;

    logic        req0, req1;
    logic        we0, we1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  size0, size1;
    logic        sext0, sext1;
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        err0, err1;
    logic [31:0] dm_a;
    logic [31:0] dm_wd;
    logic [3:0]  dm_be;
    logic        dm_mwrite;
    logic [31:0] dm_mrd;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
               size0, size1, sext0, sext1, dm_mrd,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               dm_a, dm_wd, dm_be, dm_mwrite
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
               size0, size1, sext0, sext1, dm_mrd,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               dm_a, dm_wd, dm_be, dm_mwrite
    );

endinterface

// File: rtl/dm_lane.sv
// Byte-lane steering: byte enables, write-data replication, alignment and load extraction.
module dm_lane
    import dm_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mrd,
    input  logic        sext,
    output logic [3:0]  be,
    output logic [31:0] wd,
    output logic        aligned,
    output logic [31:0] ld_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        be       = BE_NONE;
        wd       = wdata;
        aligned  = 1'b0;
        ld_data  = '0;
        half_sel = addr_lo[1] ? mrd[31:16] : mrd[15:0];
        byte_sel = mrd[7:0];
        case (addr_lo)
            2'b01:   byte_sel = mrd[15:8];
            2'b10:   byte_sel = mrd[23:16];
            2'b11:   byte_sel = mrd[31:24];
            default: byte_sel = mrd[7:0];
        endcase

        case (size)
            SZ_WORD: begin
                be      = BE_WORD;
                wd      = wdata;
                aligned = (addr_lo == 2'b00);
                ld_data = mrd;
            end
            SZ_HALF: begin
                be      = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wd      = {2{wdata[15:0]}};
                aligned = ~addr_lo[0];
                ld_data = {{16{sext & half_sel[15]}}, half_sel};
            end
            SZ_BYTE: begin
                be      = BE_BYTE << addr_lo;
                wd      = {4{wdata[7:0]}};
                aligned = 1'b1;
                ld_data = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            default: begin
                // size 11 is never legal; aligned stays 0 so it reports err
                be      = BE_NONE;
                aligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter giving two requesters single-cycle access to one data memory.
//  state  | meaning
//  S_IDLE | waiting for a request; grant pulses combinationally here
//  S_ACC  | latched access driven onto dm_*; load data captured at the edge
//  S_RESP | rvalid/err pulse to the served requester
module dm_arbiter
    import dm_arb_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    dm_arbiter_if.slave   bus
);

    state_t      state, state_nxt;
    logic        last_sel;
    logic        sel_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic        err_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        any_req;
    logic        win;
    logic        gnt0_c, gnt1_c, rvalid0_c, rvalid1_c, err0_c, err1_c;
    logic [31:0] dm_a_c, dm_wd_c;
    logic [3:0]  dm_be_c;
    logic        dm_mwrite_c;

    logic [3:0]  lane_be;
    logic [31:0] lane_wd;
    logic        lane_aligned;
    logic [31:0] lane_ld;

    dm_lane u_lane (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .wdata   (wdata_q),
        .mrd     (bus.dm_mrd),
        .sext    (sext_q),
        .be      (lane_be),
        .wd      (lane_wd),
        .aligned (lane_aligned),
        .ld_data (lane_ld)
    );

    assign any_req = bus.req0 | bus.req1;
    // on a tie, serve whoever was not served last; otherwise the lone requester
    assign win     = (bus.req0 & bus.req1) ? ~last_sel : bus.req1;

    always_comb begin
        state_nxt   = state;
        gnt0_c      = 1'b0;
        gnt1_c      = 1'b0;
        rvalid0_c   = 1'b0;
        rvalid1_c   = 1'b0;
        err0_c      = 1'b0;
        err1_c      = 1'b0;
        dm_a_c      = '0;
        dm_wd_c     = '0;
        dm_be_c     = BE_NONE;
        dm_mwrite_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_ACC;
                    gnt0_c    = ~win;
                    gnt1_c    = win;
                end
            end
            S_ACC: begin
                state_nxt   = S_RESP;
                dm_a_c      = {addr_q[31:2], 2'b00};
                dm_wd_c     = lane_wd;
                dm_be_c     = lane_aligned ? lane_be : BE_NONE;
                dm_mwrite_c = we_q & lane_aligned;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
                rvalid0_c = ~sel_q;
                rvalid1_c = sel_q;
                err0_c    = ~sel_q & err_q;
                err1_c    = sel_q & err_q;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            last_sel <= 1'b1;
            sel_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= SZ_BYTE;
            sext_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && any_req) begin
                sel_q    <= win;
                last_sel <= win;
                we_q     <= win ? bus.we1    : bus.we0;
                addr_q   <= win ? bus.addr1  : bus.addr0;
                wdata_q  <= win ? bus.wdata1 : bus.wdata0;
                size_q   <= win ? bus.size1  : bus.size0;
                sext_q   <= win ? bus.sext1  : bus.sext0;
            end
            if (state == S_ACC) begin
                err_q <= ~lane_aligned;
                // stores leave rdata untouched; faulted accesses return zero
                if (!lane_aligned) begin
                    if (sel_q) rdata1_q <= '0;
                    else       rdata0_q <= '0;
                end else if (!we_q) begin
                    if (sel_q) rdata1_q <= lane_ld;
                    else       rdata0_q <= lane_ld;
                end
            end
        end
    end

    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.rvalid0   = rvalid0_c;
    assign bus.rvalid1   = rvalid1_c;
    assign bus.err0      = err0_c;
    assign bus.err1      = err1_c;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.dm_a      = dm_a_c;
    assign bus.dm_wd     = dm_wd_c;
    assign bus.dm_be     = dm_be_c;
    assign bus.dm_mwrite = dm_mwrite_c;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed accesses push expectations, a monitor pops and compares.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    dm_arbiter_if bus ();

    dm_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        mw;
        logic        chk_lanes;
    } acc_t;

    typedef struct {
        int          p;
        logic        err;
        logic [31:0] rdata;
        logic        chk_rd;
    } rsp_t;

    int          gnt_q[$];
    acc_t        acc_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] rd_model[2];
    logic        acc_pending = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    // monitor: grants, memory-side activity and responses
    always @(negedge clk) begin
        if (reset) begin
            acc_pending = 1'b0;
        end else begin
            if (acc_pending) begin
                acc_pending = 1'b0;
                if (acc_q.size() == 0) fail_now("acc_unexpected");
                else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    chk("dm_a", bus.dm_a, e.a);
                    chk("dm_mwrite", {31'd0, bus.dm_mwrite}, {31'd0, e.mw});
                    if (e.chk_lanes) begin
                        chk("dm_be", {28'd0, bus.dm_be}, {28'd0, e.be});
                        chk("dm_wd", bus.dm_wd, e.wd);
                    end
                end
            end else begin
                chk("dm_idle", bus.dm_a | bus.dm_wd | {27'd0, bus.dm_mwrite, bus.dm_be}, 32'd0);
            end

            if (bus.gnt0 | bus.gnt1) begin
                if (bus.gnt0 & bus.gnt1) fail_now("gnt_both");
                else if (gnt_q.size() == 0) fail_now("gnt_unexpected");
                else chk("gnt_port", {31'd0, bus.gnt1}, gnt_q.pop_front());
                acc_pending = 1'b1;
            end

            if (bus.rvalid0 | bus.rvalid1) begin
                if (bus.rvalid0 & bus.rvalid1) fail_now("rvalid_both");
                else if (rsp_q.size() == 0) fail_now("rvalid_unexpected");
                else begin
                    rsp_t r;
                    int   p;
                    r = rsp_q.pop_front();
                    p = bus.rvalid1 ? 1 : 0;
                    chk("rsp_port", p, r.p);
                    if (p == 0) begin
                        chk("err0", {31'd0, bus.err0}, {31'd0, r.err});
                        chk("err1_idle", {31'd0, bus.err1}, 32'd0);
                        if (r.chk_rd) begin
                            chk("rdata0", bus.rdata0, r.rdata);
                            rd_model[0] = r.rdata;
                        end
                        chk("rdata1_hold", bus.rdata1, rd_model[1]);
                    end else begin
                        chk("err1", {31'd0, bus.err1}, {31'd0, r.err});
                        chk("err0_idle", {31'd0, bus.err0}, 32'd0);
                        if (r.chk_rd) begin
                            chk("rdata1", bus.rdata1, r.rdata);
                            rd_model[1] = r.rdata;
                        end
                        chk("rdata0_hold", bus.rdata0, rd_model[0]);
                    end
                end
            end
        end
    end

    task automatic set_attr(input int p, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] sz, input logic sx);
        if (p == 0) begin
            bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd; bus.size0 = sz; bus.sext0 = sx;
        end else begin
            bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd; bus.size1 = sz; bus.sext1 = sx;
        end
    endtask

    task automatic set_req(input int p, input logic v);
        if (p == 0) bus.req0 = v;
        else        bus.req1 = v;
    endtask

    task automatic push_exp(input int p, input logic [31:0] ea, input logic [3:0] ebe,
                            input logic [31:0] ewd, input logic emw, input logic clanes,
                            input logic eerr, input logic [31:0] erd, input logic crd);
        acc_t a;
        rsp_t r;
        a.a = ea; a.be = ebe; a.wd = ewd; a.mw = emw; a.chk_lanes = clanes;
        r.p = p; r.err = eerr; r.rdata = erd; r.chk_rd = crd;
        gnt_q.push_back(p);
        acc_q.push_back(a);
        rsp_q.push_back(r);
    endtask

    task automatic wait_gnt(input int p);
        bit seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (p == 0 ? bus.gnt0 : bus.gnt1) seen = 1'b1;
        end
        if (!seen) fail_now($sformatf("gnt%0d_timeout", p));
    endtask

    task automatic access(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                          input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic emw, input logic clanes,
                          input logic eerr, input logic [31:0] erd, input logic crd);
        push_exp(p, ea, ebe, ewd, emw, clanes, eerr, erd, crd);
        set_attr(p, we, addr, wd, sz, sx);
        set_req(p, 1'b1);
        wait_gnt(p);
        @(posedge clk); #1;
        set_req(p, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int t_gnt[4];

    initial begin
        bus.req0 = 0; bus.req1 = 0;
        set_attr(0, 0, 0, 0, SZ_WORD, 0);
        set_attr(1, 0, 0, 0, SZ_WORD, 0);
        bus.dm_mrd = 32'h80FF1234;
        rd_model[0] = '0; rd_model[1] = '0;

        #3;
        chk("rst_outs", {26'd0, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1}, 32'd0);
        chk("rst_dm", bus.dm_a | bus.dm_wd | {27'd0, bus.dm_mwrite, bus.dm_be}, 32'd0);
        chk("rst_rdata", bus.rdata0 | bus.rdata1, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // store word
        access(0, 1, 32'h10, 32'h12345678, SZ_WORD, 0,
               32'h10, 4'b1111, 32'h12345678, 1, 1, 0, 32'h0, 0);
        // byte loads from 0x80FF1234
        access(1, 0, 32'h0, 32'h0, SZ_BYTE, 1,
               32'h0, 4'b0001, 32'h0, 0, 1, 0, 32'h00000034, 1);
        access(1, 0, 32'h3, 32'h0, SZ_BYTE, 1,
               32'h0, 4'b1000, 32'h0, 0, 1, 0, 32'hFFFFFF80, 1);
        access(1, 0, 32'h3, 32'h0, SZ_BYTE, 0,
               32'h0, 4'b1000, 32'h0, 0, 1, 0, 32'h00000080, 1);
        // half store upper lane
        access(0, 1, 32'h6, 32'h0000ABCD, SZ_HALF, 0,
               32'h4, 4'b1100, 32'hABCDABCD, 1, 1, 0, 32'h0, 0);
        // misaligned word store
        access(0, 1, 32'h2, 32'h11223344, SZ_WORD, 0,
               32'h0, 4'b0000, 32'h0, 0, 0, 1, 32'h0, 1);
        // illegal size load
        access(1, 0, 32'h0, 32'h0, SZ_ILL, 0,
               32'h0, 4'b0000, 32'h0, 0, 0, 1, 32'h0, 1);

        // contention: both held, alternate starting with req0
        set_attr(0, 0, 32'h8, 32'h0, SZ_WORD, 0);
        set_attr(1, 1, 32'h5, 32'h000000A5, SZ_BYTE, 0);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_exp(0, 32'h8, 4'b1111, 32'h0, 0, 1, 0, 32'h80FF1234, 1);
            else            push_exp(1, 32'h4, 4'b0010, 32'hA5A5A5A5, 1, 1, 0, 32'h0, 0);
        end
        bus.req0 = 1; bus.req1 = 1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(i % 2);
            t_gnt[i] = cyc;
        end
        @(posedge clk); #1;
        bus.req0 = 0; bus.req1 = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++) chk($sformatf("gnt_spacing%0d", i), t_gnt[i] - t_gnt[i-1], 3);

        // half load lower lane, leaves req0 as last served
        access(0, 0, 32'h0, 32'h0, SZ_HALF, 0,
               32'h0, 4'b0011, 32'h0, 0, 1, 0, 32'h00001234, 1);

        // reset during ACC of a store
        gnt_q.push_back(0);
        set_attr(0, 1, 32'h20, 32'hDEADBEEF, SZ_WORD, 0);
        bus.req0 = 1;
        wait_gnt(0);
        @(posedge clk); #1;
        bus.req0 = 0;
        chk("acc_mwrite", {31'd0, bus.dm_mwrite}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mwrite_drop", {31'd0, bus.dm_mwrite}, 32'd0);
        chk("rst_rdata0", bus.rdata0, 32'd0);
        rd_model[0] = '0; rd_model[1] = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // tie after reset goes to req0; req1 waits through ACC/RESP
        push_exp(0, 32'h0, 4'b0010, 32'h0, 0, 1, 0, 32'h00000012, 1);
        push_exp(1, 32'h0, 4'b1100, 32'h0, 0, 1, 0, 32'hFFFF80FF, 1);
        set_attr(0, 0, 32'h1, 32'h0, SZ_BYTE, 0);
        set_attr(1, 0, 32'h2, 32'h0, SZ_HALF, 1);
        bus.req0 = 1; bus.req1 = 1;
        wait_gnt(0);
        @(posedge clk); #1;
        bus.req0 = 0;
        wait_gnt(1);
        @(posedge clk); #1;
        bus.req1 = 0;
        repeat (4) @(posedge clk);
        #1;

        chk("queues_drained", gnt_q.size() + acc_q.size() + rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
